// File: rtl/enum_type.sv
// Shared event codes, message characters and byte-formatting helpers for the UART reporter.
package enum_type;

    localparam int unsigned VALUE_W = 16;
    localparam int unsigned BCD_W   = 20;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        REP_START = 3'd0,
        REP_OVER  = 3'd1,
        REP_SCORE = 3'd2,
        REP_LINES = 3'd3,
        REP_HOLD  = 3'd4
    } report_type;

    typedef struct packed {
        report_type         code;
        logic [VALUE_W-1:0] value;
    } event_t;

    localparam logic [BYTE_W-1:0] CHAR_CR   = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF   = 8'h0A;
    localparam logic [BYTE_W-1:0] CHAR_ZERO = 8'h30;
    localparam logic [BYTE_W-1:0] CHAR_S    = 8'h53;
    localparam logic [BYTE_W-1:0] CHAR_O    = 8'h4F;
    localparam logic [BYTE_W-1:0] CHAR_P    = 8'h50;
    localparam logic [BYTE_W-1:0] CHAR_L    = 8'h4C;
    localparam logic [BYTE_W-1:0] CHAR_H    = 8'h48;
    localparam logic [BYTE_W-1:0] CHAR_UNK  = 8'h3F;

    function automatic logic [BYTE_W-1:0] code_letter(input report_type code);
        logic [BYTE_W-1:0] l;
        case (code)
            REP_START: l = CHAR_S;
            REP_OVER:  l = CHAR_O;
            REP_SCORE: l = CHAR_P;
            REP_LINES: l = CHAR_L;
            REP_HOLD:  l = CHAR_H;
            default:   l = CHAR_UNK;
        endcase
        return l;
    endfunction

    function automatic logic [BYTE_W-1:0] digit_char(input logic [3:0] d);
        return CHAR_ZERO + BYTE_W'(d);
    endfunction

    // Byte idx of the 8-byte message: letter, five digits MSD first, CR, LF.
    function automatic logic [BYTE_W-1:0] msg_byte(input report_type         code,
                                                   input logic [BCD_W-1:0]   bcd,
                                                   input logic [IDX_W-1:0]   idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            3'd0:    b = code_letter(code);
            3'd1:    b = digit_char(bcd[19:16]);
            3'd2:    b = digit_char(bcd[15:12]);
            3'd3:    b = digit_char(bcd[11:8]);
            3'd4:    b = digit_char(bcd[7:4]);
            3'd5:    b = digit_char(bcd[3:0]);
            3'd6:    b = CHAR_CR;
            default: b = CHAR_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: 16-bit binary to five BCD digits in exactly 16 cycles.
module bin2bcd
    import enum_type::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic [VALUE_W-1:0] i_bin,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd
);

    localparam int unsigned SR_W   = BCD_W + VALUE_W;
    localparam int unsigned DIGITS = BCD_W / 4;
    localparam int unsigned CNT_W  = 4;

    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_done;

    // One shift-and-add-3 iteration over the combined {bcd, binary} register.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (t[VALUE_W + 4*d +: 4] >= 4'd5)
                t[VALUE_W + 4*d +: 4] = t[VALUE_W + 4*d +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // The start cycle performs the first iteration, so done lands 16 cycles after start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_sr     <= dd_step({BCD_W'(0), i_bin});
                r_cnt    <= CNT_W'(1);
                r_active <= 1'b1;
            end else if (r_active) begin
                r_sr  <= dd_step(r_sr);
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(VALUE_W - 1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_sr[SR_W-1:VALUE_W];

endmodule

// File: rtl/uart_reporter.sv
// Queues game events and streams each as an 8-byte ASCII line ("P01234\r\n") to an external UART.
module uart_reporter
    import enum_type::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ev_valid,
    input  report_type         ev_code,
    input  logic [VALUE_W-1:0] ev_value,
    input  logic               is_transmitting,
    output logic               transmit,
    output logic [BYTE_W-1:0]  tx_byte,
    output logic               busy,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SEND,
        WAIT_START,
        WAIT_DONE
    } state_t;

    event_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_drop_cnt;

    state_t            r_state;
    report_type        r_code;
    logic [BCD_W-1:0]  r_bcd;
    logic [IDX_W-1:0]  r_idx;
    logic              r_transmit;
    logic [BYTE_W-1:0] r_tx_byte;

    logic              w_push;
    logic              w_pop;
    event_t            w_head;
    logic              w_conv_done;
    logic [BCD_W-1:0]  w_bcd;

    // Space is judged on the count before this edge; a same-cycle pop does not help.
    assign w_push = ev_valid && (r_count < CNT_W'(FIFO_DEPTH));
    assign w_pop  = (r_state == IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= '{code: ev_code, value: ev_value};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (ev_valid && !w_push && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Conversion starts on the pop edge itself so the first byte is ready 18 cycles after the push.
    bin2bcd u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_pop),
        .i_bin   (w_head.value),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_code     <= REP_START;
            r_bcd      <= '0;
            r_idx      <= '0;
            r_transmit <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_code  <= w_head.code;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (w_conv_done) begin
                        r_bcd   <= w_bcd;
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (!is_transmitting) begin
                        r_transmit <= 1'b1;
                        r_tx_byte  <= msg_byte(r_code, r_bcd, r_idx);
                        r_state    <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (is_transmitting)
                        r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!is_transmitting) begin
                        if (r_idx == IDX_W'(7)) begin
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign transmit = r_transmit;
    assign tx_byte  = r_tx_byte;
    assign drop_cnt = r_drop_cnt;
    assign busy     = (r_state != IDLE) || (r_count != '0);

endmodule

// File: tb/tb_uart_reporter.sv
// Directed self-checking bench for uart_reporter with a behavioural UART busy model.
module tb_uart_reporter;
    import enum_type::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ev_valid = 1'b0;
    report_type  ev_code = REP_START;
    logic [15:0] ev_value = 16'd0;
    logic        is_transmitting = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         uart_hold = 3;
    bit         uart_stall = 1'b0;
    int         busy_ctr = 0;
    int         tx_violations = 0;
    int         tx_unstable = 0;
    logic [7:0] last_byte = 8'h00;

    uart_reporter #(.FIFO_DEPTH(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ev_valid        (ev_valid),
        .ev_code         (ev_code),
        .ev_value        (ev_value),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: goes busy on each strobe for uart_hold cycles, or stays busy while stalled.
    always @(negedge clk) begin
        if (transmit === 1'b1) begin
            if (is_transmitting) tx_violations++;
            rx_q.push_back(tx_byte);
            rx_cyc.push_back(cyc);
            last_byte = tx_byte;
            busy_ctr = uart_hold;
            is_transmitting = 1'b1;
        end else if (busy_ctr > 0) begin
            if (tx_byte !== last_byte) tx_unstable++;
            busy_ctr--;
            if (busy_ctr == 0) is_transmitting = uart_stall;
        end else begin
            is_transmitting = uart_stall;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] get_msg(input int base);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            if (base + i < rx_q.size()) m = {m[55:0], rx_q[base + i]};
            else m = {m[55:0], 8'h00};
        return m;
    endfunction

    function automatic logic [63:0] fmt(input logic [7:0] l, input int v);
        return {l, 8'(48 + (v / 10000) % 10), 8'(48 + (v / 1000) % 10), 8'(48 + (v / 100) % 10),
                8'(48 + (v / 10) % 10), 8'(48 + v % 10), 8'h0D, 8'h0A};
    endfunction

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (busy === 1'b0 && is_transmitting === 1'b0 && busy_ctr == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b required 0", transmit); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h required 00", tx_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_message();
        bit ok;
        int push_cyc;
        clear_rx();
        uart_hold = 3;
        @(negedge clk);
        ev_valid = 1'b1; ev_code = REP_SCORE; ev_value = 16'd1234;
        @(negedge clk);
        push_cyc = cyc;
        ev_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy %b required idle", busy); end
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL single_count: got %0d required 8", rx_q.size()); end
        checks++; if (get_msg(0) !== "P01234\r\n") begin errors++; $display("FAIL single_bytes: got %h required %h", get_msg(0), 64'("P01234\r\n")); end
        if (rx_cyc.size() > 0) begin
            checks++; if (rx_cyc[0] - push_cyc != 18) begin errors++; $display("FAIL single_latency: got %0d required 18", rx_cyc[0] - push_cyc); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_rx();
        @(negedge clk);
        ev_valid = 1'b1; ev_code = REP_OVER; ev_value = 16'd65535;
        @(negedge clk);
        ev_code = REP_LINES; ev_value = 16'd0;
        @(negedge clk);
        ev_valid = 1'b0;
        wait_idle(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy %b required idle", busy); end
        checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d required 16", rx_q.size()); end
        checks++; if (get_msg(0) !== "O65535\r\n") begin errors++; $display("FAIL b2b_msg0: got %h required %h", get_msg(0), 64'("O65535\r\n")); end
        checks++; if (get_msg(8) !== "L00000\r\n") begin errors++; $display("FAIL b2b_msg1: got %h required %h", get_msg(8), 64'("L00000\r\n")); end
    endtask

    task automatic test_letters();
        bit ok;
        clear_rx();
        @(negedge clk);
        ev_valid = 1'b1; ev_code = REP_START; ev_value = 16'd7;
        @(negedge clk);
        ev_code = REP_HOLD; ev_value = 16'd100;
        @(negedge clk);
        ev_code = report_type'(3'd6); ev_value = 16'd42;
        @(negedge clk);
        ev_valid = 1'b0;
        wait_idle(6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL letters_timeout: got busy %b required idle", busy); end
        checks++; if (get_msg(0) !== "S00007\r\n") begin errors++; $display("FAIL letters_start: got %h required %h", get_msg(0), 64'("S00007\r\n")); end
        checks++; if (get_msg(8) !== "H00100\r\n") begin errors++; $display("FAIL letters_hold: got %h required %h", get_msg(8), 64'("H00100\r\n")); end
        checks++; if (get_msg(16) !== "?00042\r\n") begin errors++; $display("FAIL letters_undef: got %h required %h", get_msg(16), 64'("?00042\r\n")); end
    endtask

    task automatic test_fifo_overflow();
        clear_rx();
        uart_stall = 1'b1;
        repeat (2) @(negedge clk);
        ev_valid = 1'b1; ev_code = REP_SCORE; ev_value = 16'd9;
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            ev_valid = 1'b1; ev_code = REP_LINES; ev_value = 16'(1000 + i);
            @(negedge clk);
        end
        ev_valid = 1'b0;
        #1;
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL ovf_stalled: got %0d bytes required 0", rx_q.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b required 1", busy); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop_cnt: got %0d required 2", drop_cnt); end
    endtask

    task automatic test_drop_saturate();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ev_valid = 1'b1; ev_code = REP_HOLD; ev_value = 16'(i);
        end
        @(negedge clk);
        ev_valid = 1'b0;
        #1;
        checks++; if (drop_cnt !== 8'd102) begin errors++; $display("FAIL sat_mid: got %0d required 102", drop_cnt); end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ev_valid = 1'b1; ev_code = REP_HOLD; ev_value = 16'(i);
        end
        @(negedge clk);
        ev_valid = 1'b0;
        #1;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_end: got %0d required 255", drop_cnt); end
    endtask

    task automatic test_drain();
        bit ok;
        logic [63:0] exp;
        @(negedge clk);
        uart_stall = 1'b0;
        wait_idle(8000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drain_timeout: got busy %b required idle", busy); end
        checks++; if (rx_q.size() != 72) begin errors++; $display("FAIL drain_count: got %0d required 72", rx_q.size()); end
        checks++; if (get_msg(0) !== "P00009\r\n") begin errors++; $display("FAIL drain_preload: got %h required %h", get_msg(0), 64'("P00009\r\n")); end
        for (int m = 0; m < 8; m++) begin
            exp = fmt(CHAR_L, 1000 + m);
            checks++; if (get_msg(8 * (m + 1)) !== exp) begin errors++; $display("FAIL drain_msg%0d: got %h required %h", m, get_msg(8 * (m + 1)), exp); end
        end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drain_drop_hold: got %0d required 255", drop_cnt); end
    endtask

    task automatic test_slow_uart();
        bit ok;
        clear_rx();
        tx_unstable = 0;
        uart_hold = 500;
        @(negedge clk);
        ev_valid = 1'b1; ev_code = REP_START; ev_value = 16'd7;
        @(negedge clk);
        ev_valid = 1'b0;
        wait_idle(20000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL slow_timeout: got busy %b required idle", busy); end
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL slow_count: got %0d required 8", rx_q.size()); end
        checks++; if (get_msg(0) !== "S00007\r\n") begin errors++; $display("FAIL slow_bytes: got %h required %h", get_msg(0), 64'("S00007\r\n")); end
        checks++; if (tx_unstable != 0) begin errors++; $display("FAIL slow_stable: got %0d changes required 0", tx_unstable); end
        checks++; if (tx_violations != 0) begin errors++; $display("FAIL strobe_protocol: got %0d violations required 0", tx_violations); end
        uart_hold = 3;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        int push_cyc;
        clear_rx();
        @(negedge clk);
        ev_valid = 1'b1; ev_code = REP_SCORE; ev_value = 16'd555;
        @(negedge clk);
        ev_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (transmit === 1'b1 && rx_q.size() == 3) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_reach: got %0d bytes required 4th strobe", rx_q.size()); end
        reset_n = 1'b0;
        #1;
        checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL rmid_transmit: got %b required 0", transmit); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop_cnt: got %0d required 0", drop_cnt); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rmid_tx_byte: got %h required 00", tx_byte); end
        clear_rx();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ev_valid = 1'b1; ev_code = REP_HOLD; ev_value = 16'd321;
        @(negedge clk);
        push_cyc = cyc;
        ev_valid = 1'b0;
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got busy %b required idle", busy); end
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL rmid_count: got %0d required 8", rx_q.size()); end
        checks++; if (get_msg(0) !== "H00321\r\n") begin errors++; $display("FAIL rmid_bytes: got %h required %h", get_msg(0), 64'("H00321\r\n")); end
        if (rx_cyc.size() > 0) begin
            checks++; if (rx_cyc[0] - push_cyc != 18) begin errors++; $display("FAIL rmid_first_push: got %0d required 18", rx_cyc[0] - push_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_single_message();
        test_back_to_back();
        test_letters();
        test_fifo_overflow();
        test_drop_saturate();
        test_drain();
        test_slow_uart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reporter.md
UART_REPORTER -- requirements
Module: uart_reporter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ev_valid  input  1  event push strobe, one event per cycle high.
REQ-005 SHALL have port ev_code  input  report_type  event kind (REP_START, REP_OVER, REP_SCORE, REP_LINES, REP_HOLD).
REQ-006 SHALL have port ev_value  input  16  unsigned event payload.
REQ-007 SHALL have port is_transmitting  input  1  UART busy flag from uart instance.
REQ-008 SHALL have port transmit  output  1  one-cycle UART send strobe.
REQ-009 SHALL have port tx_byte  output  8  byte presented with transmit.
REQ-010 SHALL have port busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-011 SHALL have port drop_cnt  output  8  count of events lost to full FIFO, saturating at 255.

Function
REQ-012 SHALL push {ev_code, ev_value} into the FIFO when ev_valid=1 and FIFO count < FIFO_DEPTH at that edge; pop in same cycle does not free space for that push.
REQ-013 SHALL, on ev_valid=1 with FIFO full, discard the event and increment drop_cnt unless already 255.
REQ-014 SHALL implement FSM states IDLE, CONVERT, SEND, WAIT_START, WAIT_DONE.
REQ-015 IDLE: if FIFO non-empty, pop head, latch code/value, start conversion, go CONVERT; else stay.
REQ-016 CONVERT: binary-to-BCD (double dabble) of latched value, exactly 16 cycles, then SEND with byte index 0.
REQ-017 Message SHALL be 8 bytes: letter, five ASCII decimal digits zero-padded (most significant first), 8'h0D, 8'h0A.
REQ-018 Letter map: REP_START 'S', REP_OVER 'O', REP_SCORE 'P', REP_LINES 'L', REP_HOLD 'H'; undefined codes '?'.
REQ-019 SEND: when is_transmitting=0, assert transmit for exactly one cycle with tx_byte = byte[index], go WAIT_START; tx_byte SHALL hold that value until next SEND issue.
REQ-020 WAIT_START: stay until is_transmitting=1, then WAIT_DONE; transmit SHALL never be asserted twice without an intervening is_transmitting high.
REQ-021 WAIT_DONE: on is_transmitting=0, if index=7 go IDLE, else index+1 and go SEND.
REQ-022 Minimum latency SHALL be push edge -> IDLE pop next edge -> first transmit 18 cycles after push when UART idle.
REQ-023 Values > 99999 cannot occur (16-bit max 65535); 65535 SHALL render "65535".
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-025 busy SHALL be combinational from FSM state and FIFO count.

Reset
REQ-026 Assertion of reset_n=0 SHALL, asynchronously, empty FIFO, clear drop_cnt, force IDLE, transmit=0, tx_byte=0, busy=0.
REQ-027 Reset mid-message SHALL abandon the message; no further bytes of it are sent after release.
REQ-028 First push SHALL be accepted on the first rising edge with reset_n=1.

Structure
REQ-029 report_type enum and message-byte constants (CR, LF, letters) SHALL live in shared package enum_type.
REQ-030 BCD conversion SHALL be sub-module bin2bcd (start, 16-bit in, done, 20-bit BCD out); uart SHALL remain external.

Verification
REQ-031 Push REP_SCORE/1234, UART model idle -> bytes 'P','0','1','2','3','4',0D,0A in order, one transmit each.
REQ-032 Push REP_OVER/65535 then REP_LINES/0 back-to-back -> "O65535\r\n" then "L00000\r\n", no interleave.
REQ-033 Push 10 events while UART held busy, FIFO_DEPTH=8 -> 8 messages emitted, drop_cnt=2.
REQ-034 Hold is_transmitting=1 for 500 cycles after each strobe -> exactly one transmit per byte, tx_byte stable.
REQ-035 Assert reset_n=0 after 3rd byte of a message -> transmit=0 immediately, busy=0, no remaining bytes after release.
REQ-036 Push 300 events with FIFO full and UART stalled -> drop_cnt saturates at 255.
